cook_controller: RTL and testbench
==================================

Name: cook_controller

Overview:
Sequencing controller for the microwave cooking datapath. It captures keypad digits into a 3-digit BCD time (M:ST:SO) and runs a start/stop/pause/done state machine with a door interlock. It counts the time down once per second and drives the magnetron enable and the done flag. Its BCD outputs feed the existing 7-segment decode path.

Parameters:
TICKS_PER_SEC, 500, clk cycles per one-second tick (2 ms clk period in system sims; benches use 2)
CNT_W, 16, prescaler counter width; must hold TICKS_PER_SEC-1

Ports:
clk  in  1  system clock, rising edge
clearn  in  1  asynchronous active-low reset
keypad  in  10  one-hot key; bit i (i=0..8) = digit i+1, bit 9 = digit 0
startn  in  1  active-low start button, pre-synchronised
stopn  in  1  active-low stop/clear button, pre-synchronised
door_closed  in  1  1 = door closed
min_bcd  out  4  minutes digit
sec_tens_bcd  out  4  seconds-tens digit
sec_ones_bcd  out  4  seconds-ones digit
mag  out  1  magnetron enable
timer_done  out  1  cook complete, level
entry_err  out  1  one-cycle pulse when a start is rejected for an invalid time

Behaviour:
- Reset (clearn=0, async): state=IDLE; digits=0,0,0; mag=0; timer_done=0; entry_err=0; prescaler=0; key_q=0; startn_q=1; stopn_q=1.
- Edge detection uses registered previous values:
  - key press: keypad nonzero, popcount==1 and key_q==0. Multi-hot and held keys are ignored.
  - start: startn_q=1 and startn=0. stop: stopn_q=1 and stopn=0.
- Priority when events coincide in one cycle: stop > start > key.
- States are IDLE, ENTRY, COOK, PAUSE, DONE.
- IDLE / ENTRY:
  - Key press: shift left (min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key digit) and go to ENTRY. Digits update at that same edge, so they are visible next cycle. A 4th key press drops the oldest digit.
  - Stop: clear digits and go to IDLE.
  - Start with time=000 or door open: ignored.
  - Start with sec_tens>5: entry_err pulses; stay in ENTRY.
  - Otherwise start: go to COOK and clear the prescaler.
- COOK:
  - Prescaler counts 0..TICKS_PER_SEC-1. At terminal count it wraps to 0 and decrements the BCD time.
  - Decrement rules: SO>0 gives SO-1. SO=0 gives SO=9 and borrows from ST. ST=0 when borrowed gives ST=5 and borrows from M.
  - A decrement that yields 000 goes to DONE at the same edge.
  - door_closed=0 or stop: go to PAUSE, digits frozen.
  - Keypad and start are ignored.
- PAUSE:
  - Start with door closed: go to COOK with the prescaler cleared.
  - Stop: clear digits and go to IDLE.
  - Keys are ignored.
- DONE:
  - timer_done=1; digits stay 000.
  - Stop: go to IDLE.
  - Key press: go to ENTRY with digits 0,0,key.
  - Start is ignored.
- mag = (state==COOK) AND door_closed. This is combinational, so mag drops in the same cycle the door opens.
- timer_done = (state==DONE), registered state decode.
- Reset mid-COOK: mag falls asynchronously with clearn.

Decomposition:
- Shared package: state encoding constants; function mapping a keypad one-hot to a BCD digit; BCD_MAX_SEC_TENS=5.
- One sub-module, sec_tick_gen: prescaler with clear and enable inputs, emits a one-cycle tick output.
- BCD decrement and borrow logic stay inline.
- 7-segment decode stays outside this block.

Test Plan:
(All scenarios use TICKS_PER_SEC=2.)
1. Press keys 1, 4, 5, each one cycle separated by 0 -> digits 1,4,5, state ENTRY. Start -> mag=1 next cycle. After 2 cycles -> 1,4,4.
2. Enter 1,0,0 and start -> after one tick digits 0,5,9 (double borrow).
3. Enter 0,0,1 and start -> after 2 cycles digits 0,0,0, timer_done=1, mag=0. A later key 7 press -> ENTRY with 0,0,7 and timer_done=0.
4. COOK at 0,3,0, drop door_closed -> mag=0 same cycle, PAUSE, digits frozen. Close door, no start -> stays PAUSE. Start -> COOK, mag=1.
5. Enter 7,5 (0:75) and start -> entry_err one-cycle pulse, state ENTRY, mag=0. Enter 1,2,3,4 -> 2,3,4. Stop and start in the same cycle -> IDLE with digits 000.
6. Pull clearn low mid-COOK -> all outputs 0 asynchronously, state IDLE. After release, start is ignored (time 000).

Source files
------------

// File: rtl/cook_controller_pkg.sv
// Shared types and helpers for the microwave cook sequencing controller.
package cook_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    // Bit i (0..8) is digit i+1, bit 9 is digit 0; caller guarantees one-hot.
    function automatic logic [3:0] key_to_bcd(input logic [9:0] key);
        logic [3:0] digit;
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) digit = (i == 9) ? 4'd0 : 4'(i + 1);
        end
        return digit;
    endfunction

endpackage

// File: rtl/cook_controller_sec_tick_gen.sv
// One-second prescaler: counts enabled cycles and pulses tick at terminal count.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 500,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic clearn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == TERMINAL);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERMINAL) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cook_controller.sv
// Microwave cook sequencer: keypad BCD time entry, start/stop/pause/done FSM,
// door interlock and once-per-second BCD countdown.
module cook_controller
    import cook_controller_pkg::*;
#(
    parameter int TICKS_PER_SEC = 500,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       mag,
    output logic       timer_done,
    output logic       entry_err
);

    state_t    state_q, state_d;
    bcd_time_t time_q, time_d, time_dec;
    logic [9:0] key_q;
    logic      startn_q, stopn_q;
    logic      err_q, err_d;
    logic      presc_clr, tick;
    logic      key_evt, start_evt, stop_evt;
    logic [3:0] key_digit;

    assign key_evt   = (keypad != '0) && ($countones(keypad) == 1) && (key_q == '0);
    assign start_evt = startn_q && !startn;
    assign stop_evt  = stopn_q && !stopn;
    assign key_digit = key_to_bcd(keypad);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .CNT_W        (CNT_W)
    ) u_tick (
        .clk   (clk),
        .clearn(clearn),
        .clr   (presc_clr),
        .en    (state_q == ST_COOK),
        .tick  (tick)
    );

    // Seconds-ones borrows into seconds-tens, which wraps to 5 and borrows into minutes.
    always_comb begin
        time_dec = time_q;
        if (time_q.sec_ones != 4'd0) begin
            time_dec.sec_ones = time_q.sec_ones - 4'd1;
        end else begin
            time_dec.sec_ones = 4'd9;
            if (time_q.sec_tens != 4'd0) begin
                time_dec.sec_tens = time_q.sec_tens - 4'd1;
            end else begin
                time_dec.sec_tens = BCD_MAX_SEC_TENS;
                time_dec.min      = time_q.min - 4'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_clr = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (stop_evt) begin
                    time_d  = '0;
                    state_d = ST_IDLE;
                end else if (start_evt) begin
                    if ((time_q != '0) && door_closed) begin
                        if (time_q.sec_tens > BCD_MAX_SEC_TENS) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = ST_COOK;
                            presc_clr = 1'b1;
                        end
                    end
                end else if (key_evt) begin
                    time_d  = '{min: time_q.sec_tens, sec_tens: time_q.sec_ones, sec_ones: key_digit};
                    state_d = ST_ENTRY;
                end
            end
            ST_COOK: begin
                if (stop_evt || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    time_d = time_dec;
                    if (time_dec == '0) state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop_evt) begin
                    time_d  = '0;
                    state_d = ST_IDLE;
                end else if (start_evt && door_closed) begin
                    state_d   = ST_COOK;
                    presc_clr = 1'b1;
                end
            end
            ST_DONE: begin
                if (stop_evt) begin
                    time_d  = '0;
                    state_d = ST_IDLE;
                end else if (!start_evt && key_evt) begin
                    time_d  = '{min: 4'd0, sec_tens: 4'd0, sec_ones: key_digit};
                    state_d = ST_ENTRY;
                end
            end
            default: begin
                time_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            key_q    <= '0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            key_q    <= keypad;
            startn_q <= startn;
            stopn_q  <= stopn;
            err_q    <= err_d;
        end
    end

    assign min_bcd      = time_q.min;
    assign sec_tens_bcd = time_q.sec_tens;
    assign sec_ones_bcd = time_q.sec_ones;
    // Combinational so the magnetron drops in the very cycle the door opens.
    assign mag          = (state_q == ST_COOK) && door_closed;
    assign timer_done   = (state_q == ST_DONE);
    assign entry_err    = err_q;

endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller: directed scenarios plus randomized
// stimulus compared every cycle against a seconds-based behavioural model.
module tb_cook_controller;

    localparam int TPS = 2;

    logic       clk = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       startn, stopn, door_closed;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic       mag, timer_done, entry_err;

    int n_tests = 0;
    int n_fail  = 0;

    cook_controller #(.TICKS_PER_SEC(TPS), .CNT_W(16)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .min_bcd     (min_bcd),
        .sec_tens_bcd(sec_tens_bcd),
        .sec_ones_bcd(sec_ones_bcd),
        .mag         (mag),
        .timer_done  (timer_done),
        .entry_err   (entry_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ENTRY, M_COOK, M_PAUSE, M_DONE} mstate_t;
    mstate_t    m_state;
    int         m_d[3];
    int         m_cook_cycles;
    bit         m_err;
    logic [9:0] m_key_prev;
    bit         m_startn_prev, m_stopn_prev;

    task automatic model_reset();
        m_state = M_IDLE;
        m_d[0] = 0; m_d[1] = 0; m_d[2] = 0;
        m_cook_cycles = 0;
        m_err = 0;
        m_key_prev = '0;
        m_startn_prev = 1;
        m_stopn_prev = 1;
    endtask

    // Advance the model across the next rising edge using the currently driven inputs.
    task automatic model_step();
        bit key_evt, start_evt, stop_evt, err_next;
        int digit, secs;
        digit = 0;
        for (int i = 0; i < 10; i++) if (keypad[i]) digit = (i == 9) ? 0 : i + 1;
        key_evt   = (keypad != '0) && ($countones(keypad) == 1) && (m_key_prev == '0);
        start_evt = m_startn_prev && !startn;
        stop_evt  = m_stopn_prev && !stopn;
        secs      = m_d[0] * 60 + m_d[1] * 10 + m_d[2];
        err_next  = 0;
        case (m_state)
            M_IDLE, M_ENTRY: begin
                if (stop_evt) begin
                    m_d[0] = 0; m_d[1] = 0; m_d[2] = 0; m_state = M_IDLE;
                end else if (start_evt) begin
                    if (secs != 0 && door_closed) begin
                        if (m_d[1] > 5) err_next = 1;
                        else begin m_state = M_COOK; m_cook_cycles = 0; end
                    end
                end else if (key_evt) begin
                    m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = digit; m_state = M_ENTRY;
                end
            end
            M_COOK: begin
                if (stop_evt || !door_closed) m_state = M_PAUSE;
                else begin
                    m_cook_cycles++;
                    if (m_cook_cycles == TPS) begin
                        m_cook_cycles = 0;
                        secs = secs - 1;
                        m_d[0] = secs / 60; m_d[1] = (secs % 60) / 10; m_d[2] = secs % 10;
                        if (secs == 0) m_state = M_DONE;
                    end
                end
            end
            M_PAUSE: begin
                if (stop_evt) begin
                    m_d[0] = 0; m_d[1] = 0; m_d[2] = 0; m_state = M_IDLE;
                end else if (start_evt && door_closed) begin
                    m_state = M_COOK; m_cook_cycles = 0;
                end
            end
            M_DONE: begin
                if (stop_evt) begin
                    m_d[0] = 0; m_d[1] = 0; m_d[2] = 0; m_state = M_IDLE;
                end else if (!start_evt && key_evt) begin
                    m_d[0] = 0; m_d[1] = 0; m_d[2] = digit; m_state = M_ENTRY;
                end
            end
            default: m_state = M_IDLE;
        endcase
        m_err = err_next;
        m_key_prev = keypad;
        m_startn_prev = startn;
        m_stopn_prev = stopn;
    endtask

    task automatic compare_all();
        check("min", min_bcd, m_d[0]);
        check("sec_tens", sec_tens_bcd, m_d[1]);
        check("sec_ones", sec_ones_bcd, m_d[2]);
        check("mag", mag, (m_state == M_COOK) && door_closed);
        check("timer_done", timer_done, m_state == M_DONE);
        check("entry_err", entry_err, m_err);
    endtask

    // Called just after a falling edge: drive, step the model, compare after the next edge.
    task automatic cycle(input logic [9:0] k, input logic s, input logic p, input logic door);
        keypad = k; startn = s; stopn = p; door_closed = door;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [9:0] key_of(input int d);
        logic [9:0] k;
        k = '0;
        if (d == 0) k[9] = 1'b1;
        else k[d - 1] = 1'b1;
        return k;
    endfunction

    task automatic press(input int d);
        cycle(key_of(d), 1'b1, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic start_btn();
        cycle('0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle_cycle();
        cycle('0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic clear_all();
        cycle('0, 1'b1, 1'b0, 1'b1);
        idle_cycle();
        cycle('0, 1'b1, 1'b0, 1'b1);
        idle_cycle();
    endtask

    task automatic check_digits(input string tag, input int m, input int st, input int so);
        check({tag, "_min"}, min_bcd, m);
        check({tag, "_st"}, sec_tens_bcd, st);
        check({tag, "_so"}, sec_ones_bcd, so);
    endtask

    initial begin
        logic [9:0] rk;
        logic       rdoor;
        int         r;

        clearn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        model_reset();
        @(negedge clk);
        check_digits("reset", 0, 0, 0);
        check("reset_mag", mag, 0);
        check("reset_done", timer_done, 0);
        check("reset_err", entry_err, 0);
        clearn = 1'b1;

        // 1: key entry, start, first decrement
        press(1); press(4);
        cycle(key_of(5), 1'b1, 1'b1, 1'b1);
        check_digits("s1_entry", 1, 4, 5);
        idle_cycle();
        start_btn();
        check("s1_mag_on", mag, 1);
        idle_cycle();
        check_digits("s1_hold", 1, 4, 5);
        idle_cycle();
        check_digits("s1_dec", 1, 4, 4);
        clear_all();

        // 2: double borrow
        press(1); press(0); press(0);
        start_btn(); idle_cycle(); idle_cycle();
        check_digits("s2_borrow", 0, 5, 9);
        clear_all();

        // 3: count to done, then new key
        press(0); press(0); press(1);
        start_btn(); idle_cycle(); idle_cycle();
        check_digits("s3_done", 0, 0, 0);
        check("s3_done_flag", timer_done, 1);
        check("s3_mag_off", mag, 0);
        idle_cycle();
        cycle(key_of(7), 1'b1, 1'b1, 1'b1);
        check_digits("s3_rekey", 0, 0, 7);
        check("s3_done_clr", timer_done, 0);
        clear_all();

        // 4: door interlock and resume
        press(3); press(0);
        start_btn();
        door_closed = 1'b0;
        #1;
        check("s4_mag_door", mag, 0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        check_digits("s4_frozen", 0, 3, 0);
        idle_cycle(); idle_cycle(); idle_cycle();
        check("s4_pause_mag", mag, 0);
        check_digits("s4_pause_dig", 0, 3, 0);
        start_btn();
        check("s4_resume_mag", mag, 1);
        clear_all();

        // 5: invalid time, shift-out, stop beats start
        press(7); press(5);
        start_btn();
        check("s5_err", entry_err, 1);
        check("s5_err_mag", mag, 0);
        idle_cycle();
        check("s5_err_pulse", entry_err, 0);
        press(1); press(2); press(3); press(4);
        check_digits("s5_shift", 2, 3, 4);
        cycle('0, 1'b0, 1'b0, 1'b1);
        check_digits("s5_stop", 0, 0, 0);
        idle_cycle();
        check("s5_stop_mag", mag, 0);

        // 6: async reset mid-cook
        press(1); press(0); press(0);
        start_btn(); idle_cycle(); idle_cycle(); idle_cycle();
        #2;
        clearn = 1'b0;
        #1;
        check("s6_rst_mag", mag, 0);
        check_digits("s6_rst", 0, 0, 0);
        check("s6_rst_done", timer_done, 0);
        model_reset();
        @(negedge clk);
        clearn = 1'b1;
        start_btn();
        idle_cycle();
        check("s6_start_ign", mag, 0);

        // randomized phase
        rdoor = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) rk = key_of(($urandom_range(0, 99) < 60) ? $urandom_range(0, 2) : $urandom_range(0, 9));
            else if (r < 17) rk = 10'($urandom);
            else rk = '0;
            if ($urandom_range(0, 99) < 3) rdoor = ~rdoor;
            cycle(rk, ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, rdoor);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
